asp_rxe: RTL and testbench
==========================

Name: asp_rxe

Overview:
- Receive engine of the ASP: the network-to-host direction, complementing the existing transmit path.
- Accepts tagged frames from the network link, checks the tag sequence, and delivers the payload to the host over a ready/ack handshake.
- ACKs each good or duplicate frame back to the remote transmitter.
- Sits beside the TX path inside ASP, sharing the clock, reset and the network frame format: tag in the upper bits, data in the lower bits.

Parameters:
- data_size, 32, payload width in bits
- tag_size, 8, sequence tag width in bits; sequence arithmetic is modulo 2^tag_size

Ports:
- clk  input  1  system clock, rising edge
- reset  input  1  asynchronous, active-low reset; 0 = reset
- network_data_ready_in  input  1  level: valid frame present on network_data_tag_in
- network_data_tag_in  input  data_size+tag_size  frame; [data_size+tag_size-1:data_size]=tag, [data_size-1:0]=data
- host_ack_in  input  1  host has consumed host_data_out
- network_ACK_out  output  1  one-cycle ACK pulse to remote transmitter
- host_data_ready_out  output  1  host_data_out valid, held until host_ack_in
- host_data_out  output  data_size  delivered payload
- tag_error_out  output  1  one-cycle pulse: out-of-sequence frame dropped
- expected_tag_out  output  tag_size  current expected sequence tag (status)

Behaviour:
- All outputs registered. Reset (reset=0, async) forces:
  - state=IDLE
  - all outputs 0
  - expected_tag=0
  - host_data_out=0
  - seen_any=0
- States: IDLE, DELIVER, ACK, WAIT_LOW.
- IDLE, sampled at edge N with network_data_ready_in=1 and tag=T, data=D:
  - T==expected_tag: host_data_out<=D, host_data_ready_out<=1, state<=DELIVER. Data visible one cycle after sampling.
  - Otherwise, if seen_any=1 and T==expected_tag-1 (mod 2^tag_size): duplicate (lost ACK). network_ACK_out<=1, state<=ACK. Nothing delivered; expected_tag unchanged.
  - Otherwise: tag_error_out<=1 for one cycle, state<=WAIT_LOW. No ACK; frame dropped.
- DELIVER:
  - host_data_out and host_data_ready_out held stable. network_data_tag_in changes are ignored.
  - On the edge where host_ack_in=1: host_data_ready_out<=0, network_ACK_out<=1, expected_tag<=expected_tag+1 (wraps 2^tag_size-1 -> 0), seen_any<=1, state<=ACK.
- ACK: network_ACK_out<=0, state<=WAIT_LOW. The ACK is exactly one cycle wide.
- WAIT_LOW:
  - Stay while network_data_ready_in=1.
  - Go to IDLE on the first edge it is sampled 0.
  - This guarantees one frame per ready assertion.
- host_ack_in outside DELIVER is ignored.
- Simultaneous network_data_ready_in and host_ack_in in IDLE: host_ack_in is ignored.
- Minimum frame cycle is 4 clocks: IDLE, DELIVER, ACK, WAIT_LOW.
- Reset mid-DELIVER discards buffered data and drops host_data_ready_out immediately (asynchronously).

Optional Feature:
- ASP_RXE_PARITY_EN defined:
  - Adds output host_parity_out (1 bit, registered, reset 0) = XOR of the data bits, i.e. the even-parity bit matching the TX host format.
  - Loaded together with host_data_out, so {host_data_out, host_parity_out} forms a data+parity host word.
- Undefined: the port and its logic are absent; all other behaviour is identical.

Decomposition:
- Shared package/header asp_defs holds:
  - default widths DATA_SIZE=32, TAG_SIZE=8
  - state encodings RXE_IDLE=0, RXE_DELIVER=1, RXE_ACK=2, RXE_WAIT_LOW=3
  - tag/data field-slice localparams, shared with the TX path
- One natural sub-module: asp_tag_checker. Combinational compare of the frame tag against expected_tag and seen_any; outputs match, duplicate and error.

Test Plan:
- Reset low, then release; frame tag=0x00, data=0xA5A5A5A5, ready=1 -> host_data_ready_out=1 and host_data_out=0xA5A5A5A5 one cycle later. Raise host_ack_in -> network_ACK_out one-cycle pulse; expected_tag_out=0x01.
- Resend tag=0x00 after the above -> no host delivery, network_ACK_out pulses once, expected_tag_out stays 0x01.
- Frame tag=0x05 while expected 0x01 -> tag_error_out one-cycle pulse, no ACK, no host_data_ready_out; engine waits for ready low.
- Hold network_data_ready_in=1 across ACK -> engine remains in WAIT_LOW, no second delivery; drop ready, then send tag=0x01 -> accepted.
- Deliver 256 sequential frames tag 0x00..0xFF -> expected_tag_out wraps to 0x00; a next frame with tag 0x00 is accepted.
- Assert reset while host_data_ready_out=1 -> all outputs 0 immediately. With ASP_RXE_PARITY_EN, data 0xA5A5A5A5 gives host_parity_out=0 and data 0xA5A5A5A4 gives 1.

Source files
------------

// File: rtl/asp_rxe_pkg.sv
// Shared ASP receive-engine definitions: default widths, frame field
// positions (common with the TX path) and the RX engine state encoding.
package asp_rxe_pkg;

   localparam int unsigned DATA_SIZE  = 32;
   localparam int unsigned TAG_SIZE   = 8;
   localparam int unsigned FRAME_SIZE = DATA_SIZE + TAG_SIZE;

   // Network frame layout: tag in the upper bits, data in the lower bits
   localparam int unsigned TAG_MSB  = FRAME_SIZE - 1;
   localparam int unsigned TAG_LSB  = DATA_SIZE;
   localparam int unsigned DATA_MSB = DATA_SIZE - 1;
   localparam int unsigned DATA_LSB = 0;

   typedef enum logic [1:0] {
      RXE_IDLE     = 2'd0,
      RXE_DELIVER  = 2'd1,
      RXE_ACK      = 2'd2,
      RXE_WAIT_LOW = 2'd3
   } rxe_state_e;

endpackage

// File: rtl/asp_rxe_if.sv
// Network/host signal bundle of the ASP receive engine.
// slave = the engine, master = the surrounding link/host environment.
// Optional macro: ASP_RXE_PARITY_EN adds host_parity_out.
interface asp_rxe_if
   import asp_rxe_pkg::*;
#(
   parameter int unsigned data_size = DATA_SIZE,
   parameter int unsigned tag_size  = TAG_SIZE
);

   logic                          network_data_ready_in;
   logic [data_size+tag_size-1:0] network_data_tag_in;
   logic                          host_ack_in;
   logic                          network_ACK_out;
   logic                          host_data_ready_out;
   logic [data_size-1:0]          host_data_out;
   logic                          tag_error_out;
   logic [tag_size-1:0]           expected_tag_out;
`ifdef ASP_RXE_PARITY_EN
   logic                          host_parity_out;
`endif

   modport slave (
      input  network_data_ready_in,
      input  network_data_tag_in,
      input  host_ack_in,
      output network_ACK_out,
      output host_data_ready_out,
      output host_data_out,
      output tag_error_out,
      output expected_tag_out
`ifdef ASP_RXE_PARITY_EN
      , output host_parity_out
`endif
   );

   modport master (
      output network_data_ready_in,
      output network_data_tag_in,
      output host_ack_in,
      input  network_ACK_out,
      input  host_data_ready_out,
      input  host_data_out,
      input  tag_error_out,
      input  expected_tag_out
`ifdef ASP_RXE_PARITY_EN
      , input  host_parity_out
`endif
   );

endinterface

// File: rtl/asp_rxe_tag_checker.sv
// Combinational sequence-tag classifier: exactly one of match/duplicate/error
// is asserted for any incoming tag.
module asp_tag_checker #(
   parameter int unsigned TAG_W = 8
) (
   input  logic [TAG_W-1:0] tag_i,
   input  logic [TAG_W-1:0] expected_tag_i,
   input  logic             seen_any_i,
   output logic             match_o,
   output logic             duplicate_o,
   output logic             error_o
);

   logic [TAG_W-1:0] prev_tag;

   // Previous tag is modulo 2^TAG_W, so 0 wraps to all-ones
   always_comb begin
      prev_tag    = expected_tag_i - TAG_W'(1);
      match_o     = (tag_i == expected_tag_i);
      duplicate_o = !match_o && seen_any_i && (tag_i == prev_tag);
      error_o     = !match_o && !duplicate_o;
   end

endmodule

// File: rtl/asp_rxe.sv
// ASP receive engine: checks the sequence tag of each network frame,
// delivers in-order payloads to the host over a ready/ack handshake and
// ACKs good or duplicate frames back to the remote transmitter.
// Optional macro: ASP_RXE_PARITY_EN adds an even-parity bit to the host word.
module asp_rxe
   import asp_rxe_pkg::*;
#(
   parameter int unsigned data_size = DATA_SIZE,
   parameter int unsigned tag_size  = TAG_SIZE
) (
   input  logic     clk,
   input  logic     reset,
   asp_rxe_if.slave rx
);

   rxe_state_e           state_q, state_d;
   logic [data_size-1:0] data_q, data_d;
   logic                 rdy_q, rdy_d;
   logic                 ack_q, ack_d;
   logic                 err_q, err_d;
   logic [tag_size-1:0]  exp_tag_q, exp_tag_d;
   logic                 seen_q, seen_d;
`ifdef ASP_RXE_PARITY_EN
   logic                 par_q, par_d;
`endif

   logic [tag_size-1:0]  frame_tag;
   logic [data_size-1:0] frame_data;
   logic                 tag_match, tag_dup, tag_err;

   assign frame_tag  = rx.network_data_tag_in[data_size+tag_size-1:data_size];
   assign frame_data = rx.network_data_tag_in[data_size-1:0];

   asp_tag_checker #(.TAG_W(tag_size)) u_tag_checker (
      .tag_i          (frame_tag),
      .expected_tag_i (exp_tag_q),
      .seen_any_i     (seen_q),
      .match_o        (tag_match),
      .duplicate_o    (tag_dup),
      .error_o        (tag_err)
   );

   // State and registered outputs; reset clears everything asynchronously
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q   <= RXE_IDLE;
         data_q    <= '0;
         rdy_q     <= 1'b0;
         ack_q     <= 1'b0;
         err_q     <= 1'b0;
         exp_tag_q <= '0;
         seen_q    <= 1'b0;
`ifdef ASP_RXE_PARITY_EN
         par_q     <= 1'b0;
`endif
      end else begin
         state_q   <= state_d;
         data_q    <= data_d;
         rdy_q     <= rdy_d;
         ack_q     <= ack_d;
         err_q     <= err_d;
         exp_tag_q <= exp_tag_d;
         seen_q    <= seen_d;
`ifdef ASP_RXE_PARITY_EN
         par_q     <= par_d;
`endif
      end
   end

   // Next-state logic; ACK and tag-error are single-cycle pulses by default
   always_comb begin
      state_d   = state_q;
      data_d    = data_q;
      rdy_d     = rdy_q;
      ack_d     = 1'b0;
      err_d     = 1'b0;
      exp_tag_d = exp_tag_q;
      seen_d    = seen_q;
`ifdef ASP_RXE_PARITY_EN
      par_d     = par_q;
`endif
      case (state_q)
         RXE_IDLE: begin
            if (rx.network_data_ready_in) begin
               if (tag_match) begin
                  data_d  = frame_data;
                  rdy_d   = 1'b1;
`ifdef ASP_RXE_PARITY_EN
                  par_d   = ^frame_data;
`endif
                  state_d = RXE_DELIVER;
               end else if (tag_dup) begin
                  ack_d   = 1'b1;
                  state_d = RXE_ACK;
               end else if (tag_err) begin
                  err_d   = 1'b1;
                  state_d = RXE_WAIT_LOW;
               end
            end
         end
         RXE_DELIVER: begin
            if (rx.host_ack_in) begin
               rdy_d     = 1'b0;
               ack_d     = 1'b1;
               exp_tag_d = exp_tag_q + tag_size'(1);
               seen_d    = 1'b1;
               state_d   = RXE_ACK;
            end
         end
         RXE_ACK: begin
            state_d = RXE_WAIT_LOW;
         end
         RXE_WAIT_LOW: begin
            if (!rx.network_data_ready_in) begin
               state_d = RXE_IDLE;
            end
         end
         default: begin
            state_d = RXE_IDLE;
         end
      endcase
   end

   assign rx.network_ACK_out     = ack_q;
   assign rx.host_data_ready_out = rdy_q;
   assign rx.host_data_out       = data_q;
   assign rx.tag_error_out       = err_q;
   assign rx.expected_tag_out    = exp_tag_q;
`ifdef ASP_RXE_PARITY_EN
   assign rx.host_parity_out     = par_q;
`endif

endmodule

// File: tb/tb_asp_rxe.sv
// Self-checking bench for asp_rxe: directed vector table, randomized frames
// against a sequence-rule reference model, tag wrap and async reset cases.
module tb_asp_rxe;

   localparam int K_DEL = 0;
   localparam int K_DUP = 1;
   localparam int K_ERR = 2;

   logic clk;
   logic reset;

   asp_rxe_if #(.data_size(32), .tag_size(8)) bus ();

   asp_rxe #(.data_size(32), .tag_size(8)) dut (
      .clk   (clk),
      .reset (reset),
      .rx    (bus.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_checks;
   int n_fail;

   // Reference model state: sequence rules only
   int          m_exp;
   bit          m_seen;
   logic [31:0] m_last_data;

   typedef struct {
      logic [7:0]  tag;
      logic [31:0] data;
      int          kind;
      logic [7:0]  exp_after;
      int          ack_delay;
      int          hold;
      bit          early_ack;
   } vec_t;

   vec_t vecs[7];

   task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic int predict(input logic [7:0] tag);
      if (int'(tag) == m_exp) return K_DEL;
      if (m_seen && int'(tag) == ((m_exp + 255) % 256)) return K_DUP;
      return K_ERR;
   endfunction

   // Drive one frame from IDLE and follow it back to IDLE, checking every cycle
   task automatic send_frame(input logic [7:0] tag, input logic [31:0] data, input int kind,
                             input logic [7:0] exp_after, input int ack_delay, input int hold,
                             input bit early_ack);
      logic [7:0] exp_before;
      exp_before = 8'(m_exp);
      bus.network_data_ready_in = 1'b1;
      bus.network_data_tag_in   = {tag, data};
      if (early_ack) bus.host_ack_in = 1'b1;
      tick();
      if (kind == K_DEL) begin
         check("deliver_ready", bus.host_data_ready_out, 1'b1);
         check("deliver_data", bus.host_data_out, data);
         check("deliver_no_ack_yet", bus.network_ACK_out, 1'b0);
         check("deliver_no_err", bus.tag_error_out, 1'b0);
`ifdef ASP_RXE_PARITY_EN
         check("deliver_parity", bus.host_parity_out, ^data);
`endif
         bus.network_data_tag_in = {$urandom, $urandom};
         if (!early_ack) begin
            for (int d = 0; d < ack_delay; d++) begin
               tick();
               check("deliver_hold_ready", bus.host_data_ready_out, 1'b1);
               check("deliver_hold_data", bus.host_data_out, data);
               check("deliver_hold_no_ack", bus.network_ACK_out, 1'b0);
            end
            bus.host_ack_in = 1'b1;
         end
         tick();
         check("ack_pulse", bus.network_ACK_out, 1'b1);
         check("ack_ready_low", bus.host_data_ready_out, 1'b0);
         check("ack_exp_tag", bus.expected_tag_out, exp_after);
         bus.host_ack_in = 1'b0;
         m_last_data = data;
         m_exp  = (m_exp + 1) % 256;
         m_seen = 1'b1;
         tick();
         check("ack_one_cycle", bus.network_ACK_out, 1'b0);
      end else if (kind == K_DUP) begin
         check("dup_ack_pulse", bus.network_ACK_out, 1'b1);
         check("dup_no_ready", bus.host_data_ready_out, 1'b0);
         check("dup_no_err", bus.tag_error_out, 1'b0);
         check("dup_exp_tag", bus.expected_tag_out, exp_before);
         bus.host_ack_in = 1'b0;
         tick();
         check("dup_ack_one_cycle", bus.network_ACK_out, 1'b0);
      end else begin
         check("err_pulse", bus.tag_error_out, 1'b1);
         check("err_no_ack", bus.network_ACK_out, 1'b0);
         check("err_no_ready", bus.host_data_ready_out, 1'b0);
         bus.host_ack_in = 1'b0;
         tick();
         check("err_one_cycle", bus.tag_error_out, 1'b0);
         check("err_still_no_ack", bus.network_ACK_out, 1'b0);
      end
      for (int h = 0; h < hold; h++) begin
         tick();
         check("waitlow_no_ready", bus.host_data_ready_out, 1'b0);
         check("waitlow_no_ack", bus.network_ACK_out, 1'b0);
         check("waitlow_no_err", bus.tag_error_out, 1'b0);
      end
      bus.network_data_ready_in = 1'b0;
      tick();
      check("frame_exp_tag", bus.expected_tag_out, exp_after);
      check("frame_host_data", bus.host_data_out, m_last_data);
   endtask

   task automatic do_reset();
      bus.network_data_ready_in = 1'b0;
      bus.host_ack_in = 1'b0;
      reset = 1'b0;
      m_exp = 0;
      m_seen = 1'b0;
      m_last_data = '0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      reset = 1'b1;
      #1;
   endtask

   initial begin
      n_checks = 0;
      n_fail   = 0;
      bus.network_data_ready_in = 1'b0;
      bus.network_data_tag_in   = '0;
      bus.host_ack_in           = 1'b0;
      reset = 1'b0;
      #3;
      check("rst_ack", bus.network_ACK_out, 1'b0);
      check("rst_ready", bus.host_data_ready_out, 1'b0);
      check("rst_data", bus.host_data_out, 32'h0);
      check("rst_err", bus.tag_error_out, 1'b0);
      check("rst_exp_tag", bus.expected_tag_out, 8'h00);
      do_reset();

      // tag, data, kind, exp_after, ack_delay, hold, early_ack
      vecs[0] = '{8'h00, 32'hA5A5A5A5, K_DEL, 8'h01, 1, 0, 1'b0};
      vecs[1] = '{8'h00, 32'h12345678, K_DUP, 8'h01, 0, 0, 1'b0};
      vecs[2] = '{8'h05, 32'hDEADBEEF, K_ERR, 8'h01, 0, 2, 1'b0};
      vecs[3] = '{8'h01, 32'h0BADF00D, K_DEL, 8'h02, 0, 3, 1'b0};
      vecs[4] = '{8'h01, 32'hCAFEBABE, K_DUP, 8'h02, 0, 1, 1'b1};
      vecs[5] = '{8'hFF, 32'h55555555, K_ERR, 8'h02, 0, 0, 1'b1};
      vecs[6] = '{8'h02, 32'hA5A5A5A4, K_DEL, 8'h03, 2, 0, 1'b1};
      foreach (vecs[i])
         send_frame(vecs[i].tag, vecs[i].data, vecs[i].kind, vecs[i].exp_after,
                    vecs[i].ack_delay, vecs[i].hold, vecs[i].early_ack);

      // Randomized frames classified by the sequence rules
      for (int i = 0; i < 80; i++) begin
         logic [7:0] tag;
         int         kind;
         int         sel;
         sel = int'($urandom_range(0, 3));
         if (sel <= 1) tag = 8'(m_exp);
         else if (sel == 2) tag = 8'((m_exp + 255) % 256);
         else tag = 8'($urandom);
         kind = predict(tag);
         send_frame(tag, $urandom, kind, 8'((kind == K_DEL) ? (m_exp + 1) % 256 : m_exp),
                    int'($urandom_range(0, 3)), int'($urandom_range(0, 2)), 1'($urandom));
      end

      // Full tag wrap from a fresh reset
      do_reset();
      for (int i = 0; i < 256; i++)
         send_frame(8'(i), $urandom, K_DEL, 8'((i + 1) % 256), 0, 0, 1'b0);
      check("wrap_exp_tag_zero", bus.expected_tag_out, 8'h00);
      check("wrap_tag0_class", 64'(predict(8'h00)), 64'(K_DEL));
      send_frame(8'h00, 32'h600DF00D, K_DEL, 8'h01, 0, 0, 1'b0);
      send_frame(8'h01, 32'h11112222, K_DEL, 8'h02, 0, 0, 1'b0);

      // Async reset while data is waiting for the host
      bus.network_data_ready_in = 1'b1;
      bus.network_data_tag_in   = {8'h02, 32'hFEEDFACE};
      tick();
      check("prereset_ready", bus.host_data_ready_out, 1'b1);
      tick();
      #2;
      reset = 1'b0;
      #1;
      check("midrst_ready", bus.host_data_ready_out, 1'b0);
      check("midrst_data", bus.host_data_out, 32'h0);
      check("midrst_exp_tag", bus.expected_tag_out, 8'h00);
      check("midrst_ack", bus.network_ACK_out, 1'b0);
      check("midrst_err", bus.tag_error_out, 1'b0);
`ifdef ASP_RXE_PARITY_EN
      check("midrst_parity", bus.host_parity_out, 1'b0);
`endif
      do_reset();
      // Fresh engine: tag 0 accepted, tag 0 again is no longer a duplicate case for seen=0 cleared
      send_frame(8'h00, 32'hA5A5A5A5, K_DEL, 8'h01, 0, 0, 1'b0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #5_000_000;
      $display("FAIL timeout: simulation did not finish");
      $fatal(1);
   end

endmodule
